hash_bucket_lookup: RTL and testbench
=====================================

Name: hash_bucket_lookup

Overview:
- Consumes the 10-bit bucket index produced by the `hash` block, together with the original 64-bit name key.
- Performs lookup or insert in an internal open-addressed table using linear probing, and returns hit/miss, the slot index and a 16-bit stored value (face/entry ID).
- Sits between the `hash` stage and the PIT/FIB control logic of the NDN router.

Parameters:
- IDX_W, 10, bucket index width; table depth = 2**IDX_W.
- KEY_W, 64, key width; matches `hash` data input.
- VAL_W, 16, stored value width.
- MAX_PROBE, 8, maximum slots examined per request (1..2**IDX_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_op  in  1  0 = lookup, 1 = insert.
- req_key  in  KEY_W  name key.
- req_hash  in  IDX_W  home bucket from `hash`.
- req_val  in  VAL_W  value to store (insert only).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_hit  out  1  key was found (for insert: key already present and was updated).
- resp_full  out  1  MAX_PROBE slots examined with no match and no empty slot.
- resp_idx  out  IDX_W  slot examined last.
- resp_val  out  VAL_W  value at the matched slot (lookup hit) or the written value (insert); otherwise 0.

Behaviour:
- Reset (rst = 0, async):
  - State = IDLE; req_ready = 1; resp_valid = 0; resp_hit/full/idx/val = 0.
  - All 2**IDX_W slot valid bits cleared to 0.
  - Key/value RAM is not reset.
  - Reset mid-operation aborts any request, discards any in-flight write and drops any pending response.
- Storage:
  - Per slot: valid flop bit, plus RAM word {key, val}.
  - RAM read is synchronous, 1-cycle latency; one write port.
- Handshakes:
  - Accept on req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - resp_* held stable while resp_valid && !resp_ready.
- FSM states: IDLE, PROBE, WRITE, RESP.
  - IDLE:
    - On accept at cycle T: latch op/key/val; addr = req_hash; probe_cnt = 0; issue RAM read at req_hash.
    - Go to PROBE.
  - PROBE (one slot per cycle):
    - Valid and key match:
      - lookup: resp_hit = 1, resp_val = stored val, go to RESP.
      - insert: go to WRITE (value update, resp_hit = 1).
    - Slot empty:
      - lookup: miss, resp_val = 0, go to RESP.
      - insert: go to WRITE (resp_hit = 0).
    - Otherwise, if probe_cnt == MAX_PROBE-1: resp_full = 1, go to RESP.
    - Otherwise: addr = (addr+1) mod 2**IDX_W (wraps 1023 -> 0); probe_cnt++; issue read; stay in PROBE.
  - WRITE:
    - Write {key, val} at addr and set valid[addr].
    - resp_val = req_val; go to RESP.
  - RESP:
    - resp_valid = 1; resp_idx = addr.
    - On resp_ready: clear resp_valid, return to IDLE. Next accept is earliest the cycle after.
- Latency (resp_ready held high):
  - Lookup resolved at probe k: resp_valid asserted at cycle T+2+k.
  - Insert: T+3+k.
- Full table:
  - Insert never overwrites a non-matching valid slot.
  - Lookup on a full chain reports resp_full = 1 and resp_hit = 0.
- Keys are unique: the first match terminates the probe.

Decomposition:
- Package `ndn_hash_pkg` holds:
  - IDX_W/KEY_W/VAL_W constants shared with `hash`.
  - op encoding (OP_LOOKUP = 0, OP_INSERT = 1).
  - FSM state enum.
- One sub-module: `bucket_ram` — single-port synchronous RAM, depth 2**IDX_W, width KEY_W+VAL_W, 1-cycle read, no reset.
- Valid bits and the FSM live in the top.

Test Plan:
- Reset, then lookup key 0x1234 at hash 0x05 -> resp_hit = 0, resp_full = 0, resp_idx = 0x05, resp_val = 0, resp_valid at T+2.
- Insert key 0xAAAA val 0x0042 at hash 0x10, then lookup same -> insert resp_hit = 0, idx 0x10; lookup resp_hit = 1, val 0x0042 at T+2.
- Collision: insert keys 0x1, 0x2, 0x3 all at hash 0x3FF -> idx 0x3FF, 0x000, 0x001 (wrap); lookup 0x3 -> hit idx 0x001, latency T+4.
- MAX_PROBE = 8 full: fill slots 0x20..0x27 with distinct keys, insert a new key at hash 0x20 -> resp_full = 1, resp_hit = 0, idx 0x27, table unchanged.
- Insert existing key 0xAAAA with val 0x0099 -> resp_hit = 1, idx 0x10; later lookup returns 0x0099.
- Backpressure/reset:
  - Hold resp_ready = 0 for 5 cycles -> outputs stable and req_ready = 0.
  - Assert rst mid-PROBE -> resp_valid = 0 immediately; later lookup of a previously inserted key misses.

Source files
------------

// File: rtl/ndn_hash_pkg.sv
// Shared constants and encodings for the NDN hash / bucket lookup pipeline.
package ndn_hash_pkg;

  // Widths shared with the upstream hash block.
  localparam int HASH_IDX_W     = 10;
  localparam int HASH_KEY_W     = 64;
  localparam int HASH_VAL_W     = 16;
  localparam int HASH_MAX_PROBE = 8;

  // Request operation encoding.
  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_INSERT = 1'b1
  } op_e;

  // Lookup engine states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/bucket_ram.sv
// Single-port key/value storage for the bucket table.
// Synchronous read with one cycle of latency; contents are never reset.
module bucket_ram #(
  parameter int AW = 10,
  parameter int DW = 80
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  // One shared address: write when enabled, always register the read word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/hash_bucket_lookup.sv
// Open-addressed hash table with linear probing.
// Lookup or insert one key at a time, starting at the bucket supplied by the
// hash stage and walking at most MAX_PROBE consecutive slots (wrapping at the
// end of the table). Slot valid bits live in flops so they clear on reset;
// keys and values live in the bucket RAM.
module hash_bucket_lookup
  import ndn_hash_pkg::*;
#(
  parameter int IDX_W     = HASH_IDX_W,
  parameter int KEY_W     = HASH_KEY_W,
  parameter int VAL_W     = HASH_VAL_W,
  parameter int MAX_PROBE = HASH_MAX_PROBE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [KEY_W-1:0] req_key,
  input  logic [IDX_W-1:0] req_hash,
  input  logic [VAL_W-1:0] req_val,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic             resp_full,
  output logic [IDX_W-1:0] resp_idx,
  output logic [VAL_W-1:0] resp_val
);

  localparam int DEPTH  = 1 << IDX_W;
  localparam int WORD_W = KEY_W + VAL_W;
  localparam int PCNT_W = $clog2(MAX_PROBE + 1);
  localparam logic [PCNT_W-1:0] LAST_PROBE = PCNT_W'(MAX_PROBE - 1);

  // FSM and latched request.
  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [PCNT_W-1:0]  cnt_q, cnt_d;

  // Registered response fields, held until the next result is formed.
  logic               resp_hit_q, resp_hit_d;
  logic               resp_full_q, resp_full_d;
  logic [IDX_W-1:0]   resp_idx_q, resp_idx_d;
  logic [VAL_W-1:0]   resp_val_q, resp_val_d;

  // Per-slot occupancy.
  logic [DEPTH-1:0]   valid_q;

  // RAM port.
  logic               ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [WORD_W-1:0]  ram_wdata;
  logic [WORD_W-1:0]  ram_rdata;

  // Decoded view of the slot currently being probed.
  logic [KEY_W-1:0]   slot_key;
  logic [VAL_W-1:0]   slot_val;
  logic               slot_used;
  logic               slot_match;

  assign slot_key   = ram_rdata[WORD_W-1:VAL_W];
  assign slot_val   = ram_rdata[VAL_W-1:0];
  assign slot_used  = valid_q[addr_q];
  assign slot_match = slot_used && (slot_key == key_q);

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_hit   = resp_hit_q;
  assign resp_full  = resp_full_q;
  assign resp_idx   = resp_idx_q;
  assign resp_val   = resp_val_q;

  bucket_ram #(
    .AW (IDX_W),
    .DW (WORD_W)
  ) u_bucket_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, RAM port and response formation for the probe engine.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    val_d       = val_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    resp_hit_d  = resp_hit_q;
    resp_full_d = resp_full_q;
    resp_idx_d  = resp_idx_q;
    resp_val_d  = resp_val_q;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_wdata   = {key_q, val_q};

    unique case (state_q)
      ST_IDLE: begin
        // Read the home bucket in the accept cycle so data is ready in PROBE.
        ram_addr = req_hash;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          key_d   = req_key;
          val_d   = req_val;
          addr_d  = req_hash;
          cnt_d   = '0;
          state_d = ST_PROBE;
        end
      end

      ST_PROBE: begin
        if (slot_match) begin
          resp_hit_d  = 1'b1;
          resp_full_d = 1'b0;
          resp_idx_d  = addr_q;
          if (op_q == OP_INSERT) begin
            state_d = ST_WRITE;
          end else begin
            resp_val_d = slot_val;
            state_d    = ST_RESP;
          end
        end else if (!slot_used) begin
          resp_hit_d  = 1'b0;
          resp_full_d = 1'b0;
          resp_idx_d  = addr_q;
          if (op_q == OP_INSERT) begin
            state_d = ST_WRITE;
          end else begin
            resp_val_d = '0;
            state_d    = ST_RESP;
          end
        end else if (cnt_q == LAST_PROBE) begin
          // Chain exhausted: occupied, non-matching slots all the way.
          resp_hit_d  = 1'b0;
          resp_full_d = 1'b1;
          resp_idx_d  = addr_q;
          resp_val_d  = '0;
          state_d     = ST_RESP;
        end else begin
          // Step to the next slot; the index width gives the wrap for free.
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          ram_addr = addr_q + 1'b1;
        end
      end

      ST_WRITE: begin
        // Covers both a fresh insert and an in-place value update.
        ram_we     = 1'b1;
        ram_addr   = addr_q;
        resp_val_d = val_q;
        resp_idx_d = addr_q;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOOKUP;
      key_q       <= '0;
      val_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      resp_hit_q  <= 1'b0;
      resp_full_q <= 1'b0;
      resp_idx_q  <= '0;
      resp_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      val_q       <= val_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      resp_hit_q  <= resp_hit_d;
      resp_full_q <= resp_full_d;
      resp_idx_q  <= resp_idx_d;
      resp_val_q  <= resp_val_d;
    end
  end

  // Slot occupancy: cleared on reset, set when a slot is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (ram_we) begin
      valid_q[addr_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hash_bucket_lookup.sv
// Scoreboard bench for hash_bucket_lookup: a reference table model produces
// expected responses at request time; a monitor pops and compares them.
module tb_hash_bucket_lookup;

  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [63:0] req_key;
  logic [9:0]  req_hash;
  logic [15:0] req_val;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic        resp_full;
  logic [9:0]  resp_idx;
  logic [15:0] resp_val;

  typedef struct {
    logic        hit;
    logic        full;
    logic [9:0]  idx;
    logic [15:0] val;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  bit          m_valid [1024];
  logic [63:0] m_key   [1024];
  logic [15:0] m_val   [1024];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit lat_seen = 0;

  hash_bucket_lookup dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_hash   (req_hash),
    .req_val    (req_val),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_full  (resp_full),
    .resp_idx   (resp_idx),
    .resp_val   (resp_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  // Reference linear-probing table; updates itself for inserts.
  function automatic exp_t model_req(input bit op, input logic [63:0] key,
                                     input logic [9:0] hash, input logic [15:0] val);
    exp_t e;
    logic [9:0] a;
    e.hit = 1'b0; e.full = 1'b0; e.idx = '0; e.val = '0; e.lat = 0; e.acc = 0;
    for (int k = 0; k < MAXP; k++) begin
      a = hash + 10'(k);
      if (m_valid[a] && m_key[a] == key) begin
        e.hit = 1'b1;
        e.idx = a;
        if (op) begin
          m_val[a] = val; e.val = val; e.lat = 3 + k;
        end else begin
          e.val = m_val[a]; e.lat = 2 + k;
        end
        return e;
      end
      if (!m_valid[a]) begin
        e.idx = a;
        if (op) begin
          m_valid[a] = 1'b1; m_key[a] = key; m_val[a] = val;
          e.val = val; e.lat = 3 + k;
        end else begin
          e.val = '0; e.lat = 2 + k;
        end
        return e;
      end
    end
    e.full = 1'b1;
    e.idx  = hash + 10'(MAXP - 1);
    e.lat  = 2 + MAXP - 1;
    return e;
  endfunction

  // Response monitor: latency on first resp_valid cycle, fields on handshake.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      lat_seen = 1'b0;
    end else if (resp_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_resp idx=%0h hit=%0b", resp_idx, resp_hit);
      end else begin
        if (!lat_seen) begin
          lat_seen = 1'b1;
          n_vec++;
          if ((cyc - sb_q[0].acc + 1) !== sb_q[0].lat) begin
            n_err++;
            $display("FAIL latency got T+%0d want T+%0d", cyc - sb_q[0].acc + 1, sb_q[0].lat);
          end
        end
        if (resp_ready) begin
          n_vec++;
          if (resp_hit !== sb_q[0].hit) begin
            n_err++; $display("FAIL resp_hit got %0b want %0b", resp_hit, sb_q[0].hit);
          end
          n_vec++;
          if (resp_full !== sb_q[0].full) begin
            n_err++; $display("FAIL resp_full got %0b want %0b", resp_full, sb_q[0].full);
          end
          n_vec++;
          if (resp_idx !== sb_q[0].idx) begin
            n_err++; $display("FAIL resp_idx got %0h want %0h", resp_idx, sb_q[0].idx);
          end
          n_vec++;
          if (resp_val !== sb_q[0].val) begin
            n_err++; $display("FAIL resp_val got %0h want %0h", resp_val, sb_q[0].val);
          end
          $display("resp: hit=%0b full=%0b idx=%03h val=%04h", resp_hit, resp_full, resp_idx, resp_val);
          void'(sb_q.pop_front());
          lat_seen = 1'b0;
        end
      end
    end
  end

  // Drive one request (called at a negedge); returns at the negedge after accept.
  task automatic send(input bit op, input logic [63:0] key,
                      input logic [9:0] hash, input logic [15:0] val);
    exp_t e;
    int tmo;
    e = model_req(op, key, hash, val);
    req_valid = 1'b1; req_op = op; req_key = key; req_hash = hash; req_val = val;
    tmo = 0;
    while (!req_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout req_ready=%0b want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    sb_q.push_back(e);
    $display("req: op=%0d key=%0h hash=%03h val=%04h", op, key, hash, val);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo;
    tmo = 0;
    while (sb_q.size() != 0 && tmo < 100) begin
      @(negedge clk);
      #2;
      tmo++;
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_resp_valid(output bit ok);
    int tmo;
    tmo = 0;
    while (!resp_valid && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    ok = resp_valid;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout resp_valid=%0b want 1", resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_key = '0; req_hash = '0;
    req_val = '0; resp_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_hit, resp_full} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl got rdy/vld/hit/full=%b want 1000",
               {req_ready, resp_valid, resp_hit, resp_full});
    end
    n_vec++;
    if (resp_idx !== 10'h0 || resp_val !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data got idx=%0h val=%0h want 0 0", resp_idx, resp_val);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("reset: released");
  endtask

  task automatic test_lookup_miss();
    send(1'b0, 64'h1234, 10'h005, 16'h0);
    wait_idle();
  endtask

  task automatic test_insert_lookup();
    send(1'b1, 64'hAAAA, 10'h010, 16'h0042);
    wait_idle();
    send(1'b0, 64'hAAAA, 10'h010, 16'h0);
    wait_idle();
  endtask

  task automatic test_collision();
    send(1'b1, 64'h1, 10'h3FF, 16'h0011);
    wait_idle();
    send(1'b1, 64'h2, 10'h3FF, 16'h0022);
    wait_idle();
    send(1'b1, 64'h3, 10'h3FF, 16'h0033);
    wait_idle();
    send(1'b0, 64'h3, 10'h3FF, 16'h0);
    wait_idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 64'hF000 + 64'(i), 10'h020 + 10'(i), 16'h0100 + 16'(i));
      wait_idle();
    end
    send(1'b1, 64'hBEEF, 10'h020, 16'h0777);
    wait_idle();
    send(1'b0, 64'hBEEF, 10'h020, 16'h0);
    wait_idle();
    send(1'b0, 64'hF007, 10'h020, 16'h0);
    wait_idle();
  endtask

  task automatic test_update();
    send(1'b1, 64'hAAAA, 10'h010, 16'h0099);
    wait_idle();
    send(1'b0, 64'hAAAA, 10'h010, 16'h0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(1'b1, 64'h100 + 64'(i), 10'h200, 16'h0A00 + 16'(i));
    for (int i = 3; i >= 0; i--) send(1'b0, 64'h100 + 64'(i), 10'h200, 16'h0);
    wait_idle();
  endtask

  task automatic test_backpressure();
    bit ok;
    resp_ready = 1'b0;
    send(1'b0, 64'hAAAA, 10'h010, 16'h0);
    wait_resp_valid(ok);
    if (ok) begin
      for (int c = 0; c < 5; c++) begin
        n_vec++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_handshake cyc%0d got vld=%0b rdy=%0b want 1 0", c, resp_valid, req_ready);
        end
        n_vec++;
        if (resp_hit !== sb_q[0].hit || resp_idx !== sb_q[0].idx || resp_val !== sb_q[0].val) begin
          n_err++;
          $display("FAIL bp_stable cyc%0d got hit=%0b idx=%0h val=%0h want %0b %0h %0h", c,
                   resp_hit, resp_idx, resp_val, sb_q[0].hit, sb_q[0].idx, sb_q[0].val);
        end
        @(negedge clk);
      end
    end
    resp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid_probe();
    bit ok;
    int tmo;
    // Lookup of an absent key on the full 0x20 chain keeps the engine probing.
    req_valid = 1'b1; req_op = 1'b0; req_key = 64'hDEAD; req_hash = 10'h020; req_val = '0;
    tmo = 0;
    while (!req_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_probe_state got rdy=%0b vld=%0b want 0 0", req_ready, resp_valid);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hit !== 1'b0 ||
        resp_idx !== 10'h0 || resp_val !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset got rdy=%0b vld=%0b hit=%0b idx=%0h val=%0h want 1 0 0 0 0",
               req_ready, resp_valid, resp_hit, resp_idx, resp_val);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(1'b0, 64'hAAAA, 10'h010, 16'h0);
    wait_idle();

    // Reset while a response is held drops it at once.
    resp_ready = 1'b0;
    send(1'b1, 64'h55, 10'h030, 16'h5555);
    wait_resp_valid(ok);
    rst = 1'b0;
    #1;
    n_vec++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_resp got vld=%0b want 0", resp_valid);
    end
    sb_q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    send(1'b0, 64'h55, 10'h030, 16'h0);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_insert_lookup();
    test_collision();
    test_full();
    test_update();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_probe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
